// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ requesters,
// sequencing grant, start strobe, completion and watchdog abort.
module uart_tx_arbiter #(
    parameter int WORD_LENGHT = 8,
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT     = 4096
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*WORD_LENGHT-1:0] data_in,
    output logic [NUM_REQ-1:0]             ack,
    output logic [NUM_REQ-1:0]             sent,
    output logic                           tx_timeout,
    output logic                           busy,
    output logic [$clog2(NUM_REQ)-1:0]     owner,
    output logic                           tx_start,
    output logic [WORD_LENGHT-1:0]         tx_data,
    input  logic                           tx_done
);

    localparam int OW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    state_t                 state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [OW-1:0]          last_q, last_d;
    logic [OW-1:0]          owner_q, owner_d;
    logic [WORD_LENGHT-1:0] data_q, data_d;
    logic [NUM_REQ-1:0]     ack_q, ack_d;
    logic [NUM_REQ-1:0]     sent_q, sent_d;
    logic                   to_q, to_d;

    logic                   win_found;
    logic [OW-1:0]          win_idx;
    logic                   timer_expired;

    assign timer_expired = (timer_q == TW'(TIMEOUT - 1));

    // Search upward from the requester after the last winner, wrapping around.
    always_comb begin : arb
        int          cand;
        logic [OW-1:0] cand_idx;
        cand      = 0;
        cand_idx  = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand     = (int'(last_q) + k) % NUM_REQ;
            cand_idx = OW'(cand);
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            last_q  <= OW'(NUM_REQ - 1);
            owner_q <= '0;
            data_q  <= '0;
            ack_q   <= '0;
            sent_q  <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            sent_q  <= sent_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_found) state_d = START;
            START:   state_d = WAIT;
            WAIT:    if (tx_done || timer_expired) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered side effects of each transition; tx_done wins over the watchdog.
    always_comb begin
        timer_d = timer_q;
        last_d  = last_q;
        owner_d = owner_q;
        data_d  = data_q;
        ack_d   = '0;
        sent_d  = '0;
        to_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    ack_d[win_idx] = 1'b1;
                    owner_d        = win_idx;
                    last_d         = win_idx;
                    data_d         = data_in[int'(win_idx)*WORD_LENGHT +: WORD_LENGHT];
                end
            end
            START: timer_d = '0;
            WAIT: begin
                if (timer_q != TW'(TIMEOUT)) timer_d = timer_q + 1'b1;
                if (tx_done)            sent_d[owner_q] = 1'b1;
                else if (timer_expired) to_d            = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        tx_start = (state_q == START);
        busy     = (state_q != IDLE);
    end

    assign ack        = ack_q;
    assign sent       = sent_q;
    assign tx_timeout = to_q;
    assign owner      = owner_q;
    assign tx_data    = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a short watchdog (TIMEOUT=8).
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [3:0]  ack, sent;
    logic        tx_timeout, busy, tx_start, tx_done;
    logic [1:0]  owner;
    logic [7:0]  tx_data;

    int errors = 0;
    int checks = 0;

    uart_tx_arbiter #(.WORD_LENGHT(8), .NUM_REQ(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in), .ack(ack), .sent(sent),
        .tx_timeout(tx_timeout), .busy(busy), .owner(owner), .tx_start(tx_start),
        .tx_data(tx_data), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; req = '0; tx_done = 1'b0; data_in = {8'h44, 8'h33, 8'h22, 8'hA5};
        step();
        checks++; if ({ack, sent, tx_timeout, busy, tx_start} !== 11'd0) begin errors++;
            $display("FAIL reset_pulses: got %b want 0", {ack, sent, tx_timeout, busy, tx_start}); end
        checks++; if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner: got %0d want 0", owner); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", tx_data); end
        rst = 1'b1;
    endtask

    task automatic test_single();
        req = 4'b0001;
        step();
        checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL single_ack: got %b want 0001", ack); end
        checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL single_start: got %b want 1", tx_start); end
        checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", tx_data); end
        req = '0;
        step();
        checks++; if ({tx_start, busy, ack} !== 6'b010000) begin errors++;
            $display("FAIL single_wait1: got %b want 010000", {tx_start, busy, ack}); end
        step(); step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        checks++; if (sent !== 4'b0001) begin errors++; $display("FAIL single_sent: got %b want 0001", sent); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", busy); end
    endtask

    task automatic test_round_robin();
        logic [3:0] expa;
        logic [7:0] expd;
        rst = 1'b0; step(); rst = 1'b1;
        data_in = {8'h44, 8'h33, 8'h22, 8'h11};
        req = 4'b1111;
        step();
        for (int f = 0; f < 5; f++) begin
            expa = 4'b0001 << (f % 4);
            expd = 8'h11 * 8'((f % 4) + 1);
            checks++; if (ack !== expa) begin errors++; $display("FAIL rr_ack%0d: got %b want %b", f, ack, expa); end
            checks++; if (tx_data !== expd) begin errors++; $display("FAIL rr_data%0d: got %h want %h", f, tx_data, expd); end
            step();
            tx_done = 1'b1;
            step();
            tx_done = 1'b0;
            checks++; if (sent !== expa) begin errors++; $display("FAIL rr_sent%0d: got %b want %b", f, sent, expa); end
            if (f == 4) req = '0;
            step();
        end
        checks++; if ({busy, owner} !== 3'b000) begin errors++; $display("FAIL rr_end: got %b want 000", {busy, owner}); end
    endtask

    task automatic test_timeout();
        req = 4'b0101;
        step();
        checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL to_ack2: got %b want 0100", ack); end
        checks++; if (owner !== 2'd2) begin errors++; $display("FAIL to_owner: got %0d want 2", owner); end
        req = 4'b0001;
        for (int w = 1; w <= 8; w++) begin
            step();
            checks++; if ({tx_timeout, sent, busy} !== 6'b000001) begin errors++;
                $display("FAIL to_wait%0d: got %b want 000001", w, {tx_timeout, sent, busy}); end
        end
        step();
        checks++; if (tx_timeout !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b want 1", tx_timeout); end
        checks++; if ({sent, busy} !== 5'b00000) begin errors++; $display("FAIL to_sent: got %b want 00000", {sent, busy}); end
        step();
        checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL to_next: got %b want 0001", ack); end
        checks++; if (tx_timeout !== 1'b0) begin errors++; $display("FAIL to_once: got %b want 0", tx_timeout); end
        req = '0;
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        checks++; if (sent !== 4'b0001) begin errors++; $display("FAIL to_sent0: got %b want 0001", sent); end
        step();
    endtask

    task automatic test_boundary();
        req = 4'b0010;
        step();
        checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL bd_ack: got %b want 0010", ack); end
        req = '0;
        for (int w = 1; w <= 8; w++) step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        checks++; if (sent !== 4'b0010) begin errors++; $display("FAIL bd_sent: got %b want 0010", sent); end
        checks++; if (tx_timeout !== 1'b0) begin errors++; $display("FAIL bd_to: got %b want 0", tx_timeout); end
        step();
        checks++; if ({tx_timeout, busy} !== 2'b00) begin errors++; $display("FAIL bd_late: got %b want 00", {tx_timeout, busy}); end
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        checks++; if ({sent, busy, tx_timeout} !== 6'd0) begin errors++;
            $display("FAIL bd_idle_done: got %b want 0", {sent, busy, tx_timeout}); end
        req = 4'b0100;
        step();
        checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL bd_ack2: got %b want 0100", ack); end
        tx_done = 1'b1;
        req = '0;
        step();
        tx_done = 1'b0;
        checks++; if ({busy, sent} !== 5'b10000) begin errors++;
            $display("FAIL bd_start_done: got %b want 10000", {busy, sent}); end
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        checks++; if (sent !== 4'b0100) begin errors++; $display("FAIL bd_sent2: got %b want 0100", sent); end
        step();
    endtask

    task automatic test_reset_in_wait();
        req = 4'b1000;
        step();
        checks++; if (ack !== 4'b1000) begin errors++; $display("FAIL rw_ack: got %b want 1000", ack); end
        req = '0;
        step(); step();
        #2 rst = 1'b0;
        #1;
        checks++; if ({busy, tx_start, ack, sent, tx_timeout} !== 11'd0) begin errors++;
            $display("FAIL rw_async: got %b want 0", {busy, tx_start, ack, sent, tx_timeout}); end
        checks++; if ({owner, tx_data} !== 10'd0) begin errors++;
            $display("FAIL rw_regs: got %h want 0", {owner, tx_data}); end
        step();
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            checks++; if ({sent, tx_timeout, busy} !== 6'd0) begin errors++;
                $display("FAIL rw_quiet%0d: got %b want 0", c, {sent, tx_timeout, busy}); end
        end
        req = 4'b0010;
        step();
        checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL rw_ack1: got %b want 0010", ack); end
        checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL rw_start: got %b want 1", tx_start); end
        req = '0;
        #2 rst = 1'b0;
        #1;
        checks++; if ({tx_start, busy} !== 2'b00) begin errors++;
            $display("FAIL rs_async_start: got %b want 00", {tx_start, busy}); end
        step();
        rst = 1'b1;
    endtask

    task automatic test_req_pulse();
        req = 4'b0001;
        step();
        checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL rp_ack0: got %b want 0001", ack); end
        req = 4'b1000;
        step();
        req = '0;
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        checks++; if (sent !== 4'b0001) begin errors++; $display("FAIL rp_sent: got %b want 0001", sent); end
        for (int c = 0; c < 20; c++) begin
            step();
            checks++; if ({ack[3], busy} !== 2'b00) begin errors++;
                $display("FAIL rp_noack%0d: got %b want 00", c, {ack[3], busy}); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_boundary();
        test_reset_in_wait();
        test_req_pulse();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
